// File: rtl/temp_sensor_pkg.sv
// Shared types, constants and the raw-to-0.1 degC conversion for the temperature sensor reader.
package temp_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CONVERT
    } state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned RAW_MSB    = 15;
    localparam int unsigned RAW_LSB    = 3;
    localparam int unsigned RAW_W      = RAW_MSB - RAW_LSB + 1;
    localparam int unsigned DECI_MUL   = 5;
    localparam int unsigned DECI_SHIFT = 3;

    localparam logic [FRAME_BITS-1:0] FAULT_PATTERN = 16'hFFFF;

    // 0.0625 degC/LSB to 0.1 degC: x*0.625 = (x*5)>>3, negatives clamp to zero
    function automatic logic [15:0] convert_frame(input logic [FRAME_BITS-1:0] frame);
        logic [RAW_W-1:0] raw;
        logic [15:0]      prod;
        raw  = frame[RAW_MSB:RAW_LSB];
        prod = 16'(raw[RAW_W-2:0]) * 16'(DECI_MUL);
        if (raw[RAW_W-1]) begin
            return 16'd0;
        end
        return prod >> DECI_SHIFT;
    endfunction

endpackage

// File: rtl/temp_sensor_reader_spi_rx_shifter.sv
// SPI mode-0 receive engine: SCLK generation, MISO synchronizer, bit counter and MSB-first shift register.
module spi_rx_shifter
    import temp_sensor_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  frame_done_c,
    output logic [FRAME_BITS-1:0] frame
);

    localparam int unsigned HC_W  = $clog2(SCLK_DIV);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    logic [HC_W-1:0]       half_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  phase;
    logic                  active;
    logic [1:0]            sync;
    logic [FRAME_BITS-1:0] shreg;
    logic                  half_end;

    assign half_end     = active && (half_cnt == HC_W'(SCLK_DIV - 1));
    assign frame_done_c = half_end && phase && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign frame        = shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], miso};
        end
    end

    // phase 0 = SCLK low half, phase 1 = high half; sample on the last cycle of the high half
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            half_cnt <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            sclk     <= 1'b0;
            shreg    <= '0;
        end else if (start) begin
            active   <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            sclk     <= 1'b0;
            shreg    <= '0;
        end else if (active) begin
            if (half_end) begin
                half_cnt <= '0;
                phase    <= ~phase;
                sclk     <= ~phase;
                if (phase) begin
                    shreg   <= {shreg[FRAME_BITS-2:0], sync[1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (frame_done_c) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/temp_sensor_reader.sv
// Periodic SPI temperature reader producing unsigned 0.1 degC words.
// Optional open-bus fault detection is enabled with `define TEMP_SENSOR_FAULT_EN.
module temp_sensor_reader
    import temp_sensor_pkg::*;
#(
    parameter int unsigned SCLK_DIV      = 25,
    parameter int unsigned SAMPLE_PERIOD = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    input  logic        spi_miso,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        busy
`ifdef TEMP_SENSOR_FAULT_EN
    , output logic      sensor_fault
`endif
);

    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned CNT_W = $clog2(SCLK_DIV);

    state_t                state;
    state_t                next_state;
    logic [PER_W-1:0]      per_cnt;
    logic [CNT_W-1:0]      phase_cnt;
    logic                  frame_start_c;
    logic                  phase_end_c;
    logic                  shift_start_c;
    logic                  frame_done_c;
    logic [FRAME_BITS-1:0] frame;
    logic                  cs_n_c;
    logic                  busy_c;
    logic                  valid_c;
    logic [15:0]           data_c;
`ifdef TEMP_SENSOR_FAULT_EN
    logic                  fault_c;
`endif

    assign frame_start_c = enable && (per_cnt == '0);
    assign phase_end_c   = (phase_cnt == CNT_W'(SCLK_DIV - 1));
    assign shift_start_c = (state == CS_SETUP) && phase_end_c;

    spi_rx_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .start        (shift_start_c),
        .miso         (spi_miso),
        .sclk         (spi_sclk),
        .frame_done_c (frame_done_c),
        .frame        (frame)
    );

    // Start-to-start period timer; parked at zero so a rising enable starts a frame at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else if (!enable || per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Times CS setup and hold; restarts on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (state != next_state) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (frame_start_c) next_state = CS_SETUP;
            CS_SETUP: if (phase_end_c)   next_state = SHIFT;
            SHIFT:    if (frame_done_c)  next_state = CS_HOLD;
            CS_HOLD:  if (phase_end_c)   next_state = CONVERT;
            CONVERT:                     next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // Next-cycle output values, registered below
    always_comb begin
        cs_n_c  = !(next_state inside {CS_SETUP, SHIFT, CS_HOLD});
        busy_c  = (next_state != IDLE);
        valid_c = 1'b0;
        data_c  = temp_data;
`ifdef TEMP_SENSOR_FAULT_EN
        fault_c = sensor_fault;
        if (state == CONVERT) begin
            if (frame == FAULT_PATTERN) begin
                fault_c = 1'b1;
            end else begin
                fault_c = 1'b0;
                valid_c = 1'b1;
                data_c  = convert_frame(frame);
            end
        end
`else
        if (state == CONVERT) begin
            valid_c = 1'b1;
            data_c  = convert_frame(frame);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            temp_valid <= 1'b0;
            temp_data  <= '0;
`ifdef TEMP_SENSOR_FAULT_EN
            sensor_fault <= 1'b0;
`endif
        end else begin
            spi_cs_n   <= cs_n_c;
            busy       <= busy_c;
            temp_valid <= valid_c;
            temp_data  <= data_c;
`ifdef TEMP_SENSOR_FAULT_EN
            sensor_fault <= fault_c;
`endif
        end
    end

endmodule

// File: doc/temp_sensor_reader.md
Name: temp_sensor_reader

Overview:
Sensor-side front end that produces the 16-bit temperature word consumed by the fire-alarm mainboard.
- Periodically reads a 16-bit frame from an SPI temperature sensor (mode 0, read-only).
- Converts the raw 0.0625 °C/LSB reading to unsigned 0.1 °C units (50.0 °C = 500).
- Presents the result on temp_data with a one-cycle temp_valid strobe.

Parameters:
SCLK_DIV, 25, clk cycles per SCLK half-period (1 MHz at 50 MHz clk); legal range >= 4.
SAMPLE_PERIOD, 5_000_000, clk cycles between frame starts (100 ms); must exceed 40*SCLK_DIV.
FRAME_BITS, 16, bits per sensor frame; fixed at 16.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
enable  input  1  level; when 1, periodic sampling runs
spi_cs_n  output  1  sensor chip select, active low
spi_sclk  output  1  serial clock; idles low
spi_miso  input  1  sensor data; asynchronous to clk, synchronized internally
temp_data  output  16  latest temperature, unsigned, 0.1 °C units
temp_valid  output  1  one-cycle pulse when temp_data updates
busy  output  1  high from CS assertion through the CONVERT state

Behaviour:
- Reset, clk, and output reset values:
  - Reset is asynchronous and active-high; clock is clk.
  - Reset values: spi_cs_n=1, spi_sclk=0, temp_data=0, temp_valid=0, busy=0.
  - Reset also clears the FSM to IDLE, the period counter, the shift register and the bit counter.
  - Reset mid-frame releases CS and SCLK immediately; no partial frame is ever converted.
- spi_miso passes through a 2-flop synchronizer before use.
- Period counter:
  - Counts while enable=1 and holds at 0 while enable=0.
  - On the first cycle enable is seen high, a frame starts immediately.
  - Thereafter a frame starts every SAMPLE_PERIOD cycles, measured start-to-start.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT.
  - IDLE -> CS_SETUP on a frame start: cs_n goes low and busy goes high.
  - CS_SETUP lasts SCLK_DIV cycles, then -> SHIFT.
  - SHIFT issues 16 SCLK periods: low half, then high half, SCLK_DIV cycles each.
    - MISO is sampled MSB-first in the last cycle of each high half, which absorbs the synchronizer latency.
    - Exactly 16 rising edges occur per frame.
  - CS_HOLD: SCLK is low and CS stays low for SCLK_DIV cycles, then cs_n=1 -> CONVERT.
  - CONVERT lasts 1 cycle. temp_data and temp_valid register on its exit edge; busy drops on the same edge; -> IDLE.
- Conversion:
  - raw = frame[15:3], a signed 13-bit value.
  - If raw < 0, the result is 0.
  - Otherwise the result is (raw*5)>>3, floor, zero-extended to 16 bits. The maximum is 2559.
- temp_data holds its value between updates. temp_valid is high for exactly one clk per completed frame.
- Deasserting enable mid-frame lets the current frame complete, including its valid pulse; no further frames start.
- SPI timing derivation: the sensor drives MISO on the SCLK falling edge, so data is stable across the high half.

Optional Feature:
TEMP_SENSOR_FAULT_EN
- When defined:
  - Adds output sensor_fault (1 bit, reset 0).
  - A frame equal to 16'hFFFF (open bus) or 16'h0000 with frame[0]=... is not used; only 16'hFFFF counts as a fault.
  - On a fault frame: sensor_fault is set, temp_data is held, and temp_valid is not pulsed.
  - The next non-FFFF frame clears sensor_fault on the CONVERT exit edge and updates normally.
- When not defined: no port is added, and 16'hFFFF converts as raw=-1, giving temp_data=0 with a valid pulse.

Decomposition:
- Package temp_sensor_pkg holds:
  - state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, CONVERT);
  - FRAME_BITS=16, RAW_MSB=15, RAW_LSB=3;
  - DECI_MUL=5, DECI_SHIFT=3;
  - FAULT_PATTERN=16'hFFFF.
- One sub-module, spi_rx_shifter, owns the SCLK half-period counter, bit counter, synchronizer and shift register, and reports frame_done with the 16-bit frame. The top level owns the FSM, period counter and conversion.

Test Plan:
- Sensor model returns 16'h1900 (raw 800, 50.0 °C) -> temp_data=500 (0x01F4), one temp_valid pulse, exactly 16 SCLK rising edges while cs_n=0.
- Frame 16'h0C88 (raw 401) -> temp_data=250 (floor of 250.6); frame 16'h7FF8 (raw 4095) -> temp_data=2559.
- Frame 16'hFB00 (raw -160, -10 °C) -> temp_data=0 with a valid pulse.
- enable held high for 3 periods (SAMPLE_PERIOD reduced to 2000, SCLK_DIV=4) -> valid pulses exactly 2000 clk apart; enable dropped mid-frame -> that frame's pulse still occurs, then no further CS activity.
- Reset asserted halfway through SHIFT -> cs_n=1 and sclk=0 in the same cycle, temp_data=0, no valid pulse; after release plus enable, a fresh full 16-bit frame runs.
- Fault frame: valid frame 16'h1900, then 16'hFFFF:
  - with TEMP_SENSOR_FAULT_EN: sensor_fault=1, temp_data stays 500, no pulse; the next 16'h1900 clears the fault.
  - without the macro: temp_data=0 with a pulse.
